// File: rtl/simon_block_feeder.sv
// simon_block_feeder: packs a 32-bit word stream into 64-bit blocks, queues
// them in a small FIFO and offers each one to the SIMON core with a
// newData / loadData handshake.
module simon_block_feeder #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                nR,
  input  logic [N-1:0]        word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                loadData,
  output logic                newData,
  output logic [1:0][N-1:0]   blockIN,
  output logic [AW:0]         count,
  output logic                half_pending
);

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_e;

  logic [1:0][N-1:0] mem_q [DEPTH];
  logic [N-1:0]      hi_q;
  logic              half_q;
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  state_e            state_q, state_d;
  logic              nd_d;
  logic [1:0][N-1:0] blk_d;
  logic              full, acc, push, pop;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == (AW+1)'(DEPTH));
  // An upper half is always taken; only the completing lower half stalls.
  assign word_ready   = !(half_q && full);
  assign acc          = word_valid && word_ready;
  assign push         = acc && half_q;
  assign half_pending = half_q;

  // Packer: hold the upper word, push the pair when the lower word arrives.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      hi_q     <= '0;
      half_q   <= 1'b0;
      wr_ptr_q <= '0;
    end else if (acc) begin
      if (half_q) begin
        half_q   <= 1'b0;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end else begin
        hi_q   <= word_in;
        half_q <= 1'b1;
      end
    end
  end

  // Block storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {hi_q, word_in};
  end

  // Offer FSM next state: latch head on entry to OFFER, pop on loadData.
  always_comb begin
    state_d = state_q;
    nd_d    = newData;
    blk_d   = blockIN;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_d = OFFER;
          nd_d    = 1'b1;
          blk_d   = mem_q[rd_ptr_q[AW-1:0]];
        end
      end
      OFFER: begin
        if (loadData) begin
          pop     = 1'b1;
          nd_d    = 1'b0;
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: begin
        state_d = IDLE;
        nd_d    = 1'b0;
      end
    endcase
  end

  // Offer FSM registers and read pointer.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q  <= IDLE;
      newData  <= 1'b0;
      blockIN  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      newData <= nd_d;
      blockIN <= blk_d;
      if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_simon_block_feeder.sv
// Bench for simon_block_feeder: directed scenarios plus a random phase, with
// a queue-based reference model and an offer monitor checking every cycle.
module tb_simon_block_feeder;
  localparam int N = 32, DEPTH = 4, AW = 2;

  logic              clk = 1'b0;
  logic              nR;
  logic [N-1:0]      word_in;
  logic              word_valid, word_ready, loadData, newData, half_pending;
  logic [1:0][N-1:0] blockIN;
  logic [AW:0]       count;

  int errors = 0;
  int checks = 0;

  simon_block_feeder #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .nR(nR), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .loadData(loadData), .newData(newData),
    .blockIN(blockIN), .count(count), .half_pending(half_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: blocks held in the FIFO (head = offered block), blocks
  // not yet offered, and the pending upper half.
  logic [63:0] mfifo[$];
  logic [63:0] exp_q[$];
  bit          mpend;
  logic [31:0] mhi;
  bit          prev_nd, had_offer;
  int          low_cnt;
  logic [63:0] held, e;

  // Monitor + model: compare outputs against model, then step the model
  // with the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    if (!nR) begin
      chk("rst_outs", {newData, count, half_pending, word_ready}, {1'b0, 3'd0, 1'b0, 1'b1});
      chk("rst_block", blockIN, 64'h0);
      mfifo.delete(); exp_q.delete();
      mpend = 0; prev_nd = 0; had_offer = 0; low_cnt = 0;
    end else begin
      bit rdy, pop;
      rdy = !(mpend && mfifo.size() == DEPTH);
      chk("count", count, 64'(mfifo.size()));
      chk("half_pending", half_pending, 64'(mpend));
      chk("word_ready", word_ready, 64'(rdy));
      if (newData && !prev_nd) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_offer: got newData rise with blockIN %h, want none", blockIN);
        end else begin
          e = exp_q.pop_front();
          chk("offer_block", blockIN, e);
        end
        if (had_offer) chk("gap_ge2", 64'(low_cnt >= 2), 64'd1);
        had_offer = 1;
        held = blockIN;
      end else if (newData) begin
        chk("block_hold", blockIN, held);
      end
      low_cnt = newData ? 0 : low_cnt + 1;
      prev_nd = newData;
      pop = newData && loadData;
      if (pop && mfifo.size() > 0) void'(mfifo.pop_front());
      if (word_valid && rdy) begin
        if (mpend) begin
          mfifo.push_back({mhi, word_in});
          exp_q.push_back({mhi, word_in});
          mpend = 0;
        end else begin
          mhi = word_in;
          mpend = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic r;
    int n;
    r = 0; n = 0;
    word_in = w; word_valid = 1;
    while (!r && n < 50) begin
      @(negedge clk); r = word_ready;
      @(posedge clk); #1; n++;
    end
    word_valid = 0;
    chk("send_accept", 64'(r), 64'd1);
  endtask

  task automatic wait_nd();
    int n;
    n = 0;
    while (!newData && n < 50) begin cyc(); n++; end
    chk("offer_wait", 64'(newData), 64'd1);
  endtask

  task automatic drain(input int nblk, input int dly);
    for (int i = 0; i < nblk; i++) begin
      wait_nd();
      repeat (dly) cyc();
      loadData = 1; cyc(); loadData = 0;
    end
  endtask

  logic [63:0] blks [5];

  initial begin
    blks[0] = 64'hA8D5F7DE0123FEDC; blks[1] = 64'h5BC92D014567BA98;
    blks[2] = 64'hF2B48D4589AB7654; blks[3] = 64'h567F11DECDEF3210;
    blks[4] = 64'h656B696C20646E75;

    // 1: reset held with word_valid asserted
    nR = 0; word_valid = 1; word_in = $urandom; loadData = 0;
    repeat (3) cyc();
    chk("t1_ready", 64'(word_ready), 64'd1);
    chk("t1_count", 64'(count), 64'd0);
    word_valid = 0; nR = 1;
    cyc();

    // 2: single block, latency and handshake
    send_word(32'h656B696C);
    chk("t2_half", 64'(half_pending), 64'd1);
    send_word(32'h20646E75);
    chk("t2_nd_E1", 64'(newData), 64'd0);
    cyc();
    chk("t2_nd_E1p1", 64'(newData), 64'd1);
    chk("t2_block", blockIN, 64'h656B696C20646E75);
    chk("t2_count1", 64'(count), 64'd1);
    loadData = 1; cyc(); loadData = 0;
    chk("t2_nd_low", 64'(newData), 64'd0);
    chk("t2_count0", 64'(count), 64'd0);
    cyc(); cyc();

    // 3: fill to full, backpressure on the lower half only
    for (int i = 0; i < 8; i++) send_word(32'hC0DE0000 + 32'(i));
    chk("t3_full", 64'(count), 64'd4);
    send_word(32'hC0DE0008);
    chk("t3_half", 64'(half_pending), 64'd1);
    word_in = 32'hC0DE0009; word_valid = 1;
    cyc(); cyc();
    chk("t3_blocked", 64'(word_ready), 64'd0);
    loadData = 1; cyc(); loadData = 0;
    chk("t3_pop", 64'(count), 64'd3);
    chk("t3_still_half", 64'(half_pending), 64'd1);
    cyc(); word_valid = 0;
    chk("t3_refill", 64'(count), 64'd4);
    chk("t3_half_clr", 64'(half_pending), 64'd0);
    drain(4, 1);
    cyc(); cyc();

    // 4: loadData ignored in IDLE and GAP
    loadData = 1; cyc(); loadData = 0; cyc();
    chk("t4_idle_nd", 64'(newData), 64'd0);
    chk("t4_idle_cnt", 64'(count), 64'd0);
    send_word(32'h0BADF00D); send_word(32'h12345678);
    wait_nd();
    loadData = 1; cyc(); cyc(); loadData = 0;
    repeat (4) cyc();
    chk("t4_gap_nd", 64'(newData), 64'd0);
    chk("t4_gap_cnt", 64'(count), 64'd0);

    // 5: five blocks streamed, each answered three cycles after newData
    fork
      for (int i = 0; i < 5; i++) begin
        send_word(blks[i][63:32]); send_word(blks[i][31:0]);
      end
      drain(5, 3);
    join
    cyc(); cyc();

    // 6: asynchronous reset mid-offer with a half pending
    send_word(32'h11112222); send_word(32'h33334444); send_word(32'h55556666);
    wait_nd();
    chk("t6_half", 64'(half_pending), 64'd1);
    @(posedge clk); #3; nR = 0; #1;
    chk("t6_async", {newData, count, half_pending}, 5'b0);
    @(posedge clk); #1; nR = 1;
    cyc();
    send_word(32'h01234567); send_word(32'h89ABCDEF);
    wait_nd();
    chk("t6_block", blockIN, 64'h0123456789ABCDEF);
    loadData = 1; cyc(); loadData = 0;
    cyc(); cyc();

    // random phase
    for (int i = 0; i < 400; i++) begin
      word_valid = ($urandom_range(0, 2) != 0);
      word_in    = $urandom;
      loadData   = ($urandom_range(0, 2) == 0);
      cyc();
    end
    word_valid = 0; loadData = 0;
    for (int i = 0; i < 200 && (count != 0 || newData); i++) begin
      loadData = newData;
      cyc();
    end
    loadData = 0;
    cyc(); cyc();
    chk("final_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
